keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_ctrl
//  Description : Matrix keypad scanner. Drives one column low at a time,
//                debounces the first key found, reports it once, keeps a
//                short history of accepted codes and waits for a debounced
//                release before resuming the scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int DWELL     = 4,
    parameter int DB_CYCLES = 20,
    parameter int DEPTH     = 2,
    localparam int KW       = $clog2(ROWS * COLS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ROWS-1:0]       row_n,
    output logic [COLS-1:0]       col_n,
    output logic                  key_valid,
    output logic [KW-1:0]         key_code,
    output logic [DEPTH*KW-1:0]   history,
    output logic                  key_held
);

    localparam int c_cnt_max_val = (DWELL > DB_CYCLES) ? DWELL : DB_CYCLES;
    localparam int c_cnt_w       = $clog2(c_cnt_max_val + 1);
    localparam int c_ciw         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_riw         = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_sat   = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_dwell_end = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0] c_db_end    = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_ciw-1:0]   c_last_col  = c_ciw'(COLS - 1);
    localparam logic [COLS-1:0]    c_col_one   = COLS'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ROWS-1:0]      r_row_meta;
    logic [ROWS-1:0]      r_row_sync;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_ciw-1:0]     r_col_idx;
    logic [c_riw-1:0]     r_row_idx;

    logic                 w_any_low;
    logic [c_riw-1:0]     w_low_row;
    logic                 w_latched_low;
    logic [c_ciw-1:0]     w_next_col;
    logic [COLS-1:0]      w_next_col_n;
    logic [KW-1:0]        w_code;
    logic                 w_accept;
    logic [c_cnt_w-1:0]   w_cnt_inc;

    // Two-flop synchronizer on the raw row lines; idle level is high
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Lowest-index low row among synchronized rows (descending loop so the lowest wins)
    always_comb begin
        w_any_low = 1'b0;
        w_low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!r_row_sync[r]) begin
                w_any_low = 1'b1;
                w_low_row = c_riw'(r);
            end
        end
    end

    assign w_latched_low = ~r_row_sync[r_row_idx];
    assign w_next_col    = (r_col_idx == c_last_col) ? '0 : r_col_idx + c_ciw'(1);
    assign w_next_col_n  = ~(c_col_one << w_next_col);
    assign w_code        = KW'(r_row_idx) * KW'(COLS) + KW'(r_col_idx);
    assign w_cnt_inc     = (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + c_cnt_w'(1);
    assign w_accept      = (r_state == ST_DEBOUNCE) && w_latched_low && (r_cnt == c_db_end);

    // Scan / debounce / hold / release sequencer with registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_col_idx <= '0;
            r_row_idx <= '0;
            col_n     <= ~c_col_one;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_cnt >= c_dwell_end) begin
                        r_cnt <= '0;
                        if (w_any_low) begin
                            // Column stays driven; only the row under it is tracked
                            r_row_idx <= w_low_row;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col_idx <= w_next_col;
                            col_n     <= w_next_col_n;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_latched_low) begin
                        r_cnt     <= '0;
                        r_col_idx <= w_next_col;
                        col_n     <= w_next_col_n;
                        r_state   <= ST_SCAN;
                    end else if (w_accept) begin
                        r_cnt     <= '0;
                        key_valid <= 1'b1;
                        key_code  <= w_code;
                        key_held  <= 1'b1;
                        r_state   <= ST_HELD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!w_latched_low) begin
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_latched_low) begin
                        r_cnt   <= '0;
                        r_state <= ST_HELD;
                    end else if (r_cnt == c_db_end) begin
                        r_cnt     <= '0;
                        key_held  <= 1'b0;
                        r_col_idx <= w_next_col;
                        col_n     <= w_next_col_n;
                        r_state   <= ST_SCAN;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_col_idx <= '0;
                    col_n     <= ~c_col_one;
                    key_held  <= 1'b0;
                    r_state   <= ST_SCAN;
                end
            endcase
        end
    end

    generate
        if (DEPTH == 1) begin : g_hist_single
            // Single slot simply holds the newest accepted code
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    history <= '0;
                end else if (w_accept) begin
                    history <= w_code;
                end
            end
        end else begin : g_hist_shift
            // Shift older codes toward the MSBs, newest code enters slot 0
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    history <= '0;
                end else if (w_accept) begin
                    history <= {history[(DEPTH-1)*KW-1:0], w_code};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_ctrl
//  Description : Self-checking bench for keypad_scan_ctrl with a keypad
//                matrix model, expected-key scoreboard and pulse monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int DWELL     = 4;
    localparam int DB_CYCLES = 20;
    localparam int DEPTH     = 2;
    localparam int KW        = 4;

    logic                clk;
    logic                nrst;
    logic [ROWS-1:0]     row_n;
    logic [COLS-1:0]     col_n;
    logic                key_valid;
    logic [KW-1:0]       key_code;
    logic [DEPTH*KW-1:0] history;
    logic                key_held;

    // press_m[r][c] = 1 means the switch at row r, column c is closed
    logic [COLS-1:0]     press_m [ROWS];

    int n_cmp;
    int n_err;

    logic [11:0]         sb_q[$];
    logic [DEPTH*KW-1:0] exp_hist;
    logic                prev_valid;

    keypad_scan_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .DWELL     (DWELL),
        .DB_CYCLES (DB_CYCLES),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .history   (history),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a row reads low when a closed switch sits on a driven (low) column
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_n[r] = ~|(press_m[r] & ~col_n);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_key(input int code);
        exp_hist = {exp_hist[KW-1:0], KW'(code)};
        sb_q.push_back({KW'(code), exp_hist});
    endtask

    task automatic wait_held(input logic level, input int budget, input string name);
        int k = 0;
        while (key_held !== level && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(key_held), 32'(level));
    endtask

    task automatic wait_col(input logic [COLS-1:0] target, input int budget, input string name);
        int k = 0;
        while (col_n !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(col_n), 32'(target));
    endtask

    task automatic press_key(input int row, input int col, input int hold);
        expect_key(row * COLS + col);
        press_m[row][col] = 1'b1;
        wait_held(1'b1, 100, "held_on");
        tick(hold);
        press_m[row][col] = 1'b0;
        wait_held(1'b0, 100, "held_off");
    endtask

    // Monitor: every key_valid pulse must match the oldest expected key
    always @(negedge clk) begin
        if (nrst) begin
            if (key_valid) begin
                if (prev_valid) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pulse_width: key_valid high on consecutive cycles at %0t", $time);
                end
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: code %0d history %0h, no key expected at %0t",
                             key_code, history, $time);
                end else begin
                    logic [11:0] e;
                    e = sb_q.pop_front();
                    check("pulse_code", 32'(key_code), 32'(e[11:8]));
                    check("pulse_history", 32'(history), 32'(e[7:0]));
                end
            end
            prev_valid <= key_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_hist   = '0;
        prev_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) press_m[r] = '0;
        nrst = 1'b0;
        tick(3);

        // Reset state
        check("rst_col_n", 32'(col_n), 32'h0E);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_history", 32'(history), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);

        // Idle scan: each column low for DWELL cycles, wrapping
        nrst = 1'b1;
        for (int p = 0; p < 40; p++) begin
            logic [COLS-1:0] exp_col;
            exp_col = ~(COLS'(1) << ((p / DWELL) % COLS));
            check("idle_col_n", 32'(col_n), 32'(exp_col));
            tick(1);
        end

        // Key 9 (row 2, column 1) held for a long time, single pulse
        expect_key(9);
        press_m[2][1] = 1'b1;
        wait_held(1'b1, 100, "k9_held_on");
        tick(100);
        check("k9_key_code", 32'(key_code), 32'd9);
        check("k9_history0", 32'(history[3:0]), 32'd9);
        check("k9_col_frozen", 32'(col_n), 32'h0D);
        check("k9_key_held", 32'(key_held), 32'h1);
        press_m[2][1] = 1'b0;
        tick(20);
        check("k9_held_20_after", 32'(key_held), 32'h1);
        check("k9_col_still", 32'(col_n), 32'h0D);
        wait_held(1'b0, 20, "k9_held_off");
        check("k9_next_col", 32'(col_n), 32'h0B);

        // Short press: 10 cycles low never reaches acceptance
        wait_col(4'b1101, 40, "short_wait_col1");
        press_m[2][1] = 1'b1;
        tick(10);
        press_m[2][1] = 1'b0;
        check("short_not_held", 32'(key_held), 32'h0);
        begin
            int k = 0;
            while (col_n === 4'b1101 && k < 40) begin
                tick(1);
                k++;
            end
        end
        check("short_resume_col2", 32'(col_n), 32'h0B);

        // Three accepted keys in sequence
        press_key(2, 1, 5);
        press_key(0, 3, 5);
        press_key(3, 3, 5);
        check("seq_history", 32'(history), 32'h3F);
        check("seq_key_code", 32'(key_code), 32'd15);

        // Rollover ignored, release bounce filtered
        expect_key(9);
        press_m[2][1] = 1'b1;
        wait_held(1'b1, 100, "roll_held_on");
        tick(5);
        press_m[0][3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            press_m[1][1] = i[0];
            tick(1);
        end
        press_m[1][1] = 1'b0;
        tick(24);
        press_m[0][3] = 1'b0;
        check("roll_col_frozen", 32'(col_n), 32'h0D);
        check("roll_key_code", 32'(key_code), 32'd9);
        tick(5);
        for (int i = 0; i < 5; i++) begin
            press_m[2][1] = i[0];
            tick(1);
        end
        tick(18);
        check("bounce_held_still", 32'(key_held), 32'h1);
        wait_held(1'b0, 30, "bounce_held_off");
        tick(60);

        // Reset in the middle of a debounce discards the key
        wait_col(4'b1101, 40, "rst_wait_col1");
        press_m[2][1] = 1'b1;
        tick(19);
        nrst = 1'b0;
        exp_hist = '0;
        #1;
        check("mid_rst_col_n", 32'(col_n), 32'h0E);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        check("mid_rst_history", 32'(history), 32'h0);
        check("mid_rst_code", 32'(key_code), 32'h0);
        check("mid_rst_held", 32'(key_held), 32'h0);
        press_m[2][1] = 1'b0;
        tick(3);
        nrst = 1'b1;
        tick(2);
        check("post_rst_col_n", 32'(col_n), 32'h0E);
        tick(50);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
